mul_iter: RTL

- Parametrised, multi-cycle iterative shift-add multiplier for the RV32M/RV64M multiply group: MUL, MULH, MULHSU, MULHU.
- Consumes RADIX_BITS multiplier bits per cycle.
- Sits in the execute stage behind a valid/ready issue port and in front of writeback.
- Adds over the prior combinational design: full-width iteration, handshakes, backpressure, flush, optional early-out.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/mul_operand_prep.sv | 29 ++
 rtl/mul_iter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative multiply unit (and the future divider).
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

  // Returns {rs1_signed, rs2_signed} for an op.
  function automatic logic [1:0] op_signed(input mul_op_e op);
    case (op)
      MUL, MULH: op_signed = 2'b11;
      MULHSU:    op_signed = 2'b10;
      default:   op_signed = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mul_operand_prep.sv
// Turns raw sources into unsigned magnitudes plus a result-negate flag.
module mul_operand_prep
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] op_a_o,
  output logic [XLEN-1:0] op_b_o,
  output logic            negate_o
);

  logic [1:0] sgn;
  logic       a_neg;
  logic       b_neg;

  // The most-negative value negates onto itself, which is its correct unsigned magnitude.
  always_comb begin
    sgn      = op_signed(mul_op_e'(op_i));
    a_neg    = sgn[1] & rs1_i[XLEN-1];
    b_neg    = sgn[0] & rs2_i[XLEN-1];
    op_a_o   = a_neg ? (~rs1_i + XLEN'(1)) : rs1_i;
    op_b_o   = b_neg ? (~rs2_i + XLEN'(1)) : rs2_i;
    negate_o = a_neg ^ b_neg;
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Retires RADIX_BITS multiplier bits per cycle behind valid/ready handshakes.
module mul_iter
  import mul_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 4,
  parameter int TAG_W      = 5,
  parameter int EARLY_OUT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mul_op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N     = XLEN / RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * XLEN;

  mul_state_e       state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negate_q, negate_d;
  logic             hi_q, hi_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [XLEN-1:0]  prep_a, prep_b;
  logic             prep_neg;
  logic             accept;
  logic             finish;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    prod;

  mul_operand_prep #(.XLEN(XLEN)) u_prep (
    .op_i     (mul_op),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .op_a_o   (prep_a),
    .op_b_o   (prep_b),
    .negate_o (prep_neg)
  );

  assign in_ready   = !rst && !flush && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_tag    = out_tag_q;

  // Early-out needs at least one retired digit so a zero multiplier still spends one cycle.
  assign finish  = (cnt_q == CNT_W'(N)) ||
                   ((EARLY_OUT != 0) && (cnt_q != '0) && (mplier_q == '0));
  assign partial = mcand_q * PW'(mplier_q[RADIX_BITS-1:0]);
  assign prod    = negate_q ? (~acc_q + PW'(1)) : acc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    negate_d  = negate_q;
    hi_d      = hi_q;
    tag_d     = tag_q;
    result_d  = result_q;
    out_tag_d = out_tag_q;

    case (state_q)
      BUSY: begin
        if (finish) begin
          state_d   = DONE;
          result_d  = hi_q ? prod[PW-1:XLEN] : prod[XLEN-1:0];
          out_tag_d = tag_q;
        end else begin
          acc_d    = acc_q + partial;
          mcand_d  = mcand_q << RADIX_BITS;
          mplier_d = mplier_q >> RADIX_BITS;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // A new op can only land from IDLE or from a DONE that is being drained this cycle.
    if (accept) begin
      state_d  = BUSY;
      acc_d    = '0;
      mcand_d  = PW'(prep_b);
      mplier_d = prep_a;
      cnt_d    = '0;
      negate_d = prep_neg;
      hi_d     = (mul_op != 2'b00);
      tag_d    = in_tag;
    end

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      negate_q  <= 1'b0;
      hi_q      <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      negate_q  <= negate_d;
      hi_q      <= hi_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      out_tag_q <= out_tag_d;
    end
  end

endmodule
